// File: rtl/uart_int_ctrl_gen2_pkg.sv
// Shared definitions for the gen2 UART interrupt controller: register offsets,
// IRQ state encoding, IIR field layout and the priority-encoder helper.
package uart_int_ctrl_gen2_pkg;

  localparam logic [3:0] ADDR_IER  = 4'h5;
  localparam logic [3:0] ADDR_ISR  = 4'h6;
  localparam logic [3:0] ADDR_IIR  = 4'h7;
  localparam logic [3:0] ADDR_MODE = 4'h8;
  localparam logic [3:0] ADDR_RAW  = 4'h9;
  localparam logic [3:0] ADDR_SET  = 4'hA;

  localparam int IIR_PEND_BIT = 4;
  localparam int IIR_ID_W     = 4;
  localparam int MAX_SRC      = 15;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'b00,
    IRQ_ASSERT = 2'b01,
    IRQ_GAP    = 2'b10
  } irqState_t;

  // Lowest set index wins; returns 0 for an all-zero vector.
  function automatic logic [IIR_ID_W-1:0] firstSetIdx(input logic [MAX_SRC-1:0] vec);
    firstSetIdx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (vec[i]) firstSetIdx = IIR_ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/uart_int_src_cell.sv
// One interrupt source: previous-value register for edge detect and the sticky
// status bit with hardware set, software W1S and W1C (set beats clear).
module uart_int_src_cell (
  input  logic DSP_CLK,
  input  logic RESET,
  input  logic src,
  input  logic enable,
  input  logic edgeMode,
  input  logic setBit,
  input  logic clrBit,
  output logic status
);

  logic srcD;
  logic hit;
  logic statusNext;

  assign hit        = enable & (edgeMode ? (src & ~srcD) : src);
  assign statusNext = hit | setBit | (status & ~clrBit);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge DSP_CLK) begin
    if (RESET) begin
      srcD   <= 1'b0;
      status <= 1'b0;
    end else begin
      srcD   <= src;
      status <= statusNext;
    end
  end

endmodule

// File: rtl/uart_int_ctrl_gen2.sv
// Gen2 UART interrupt controller: DSP bus decode, IER/MODE registers, per-source
// cells, priority-encoded IIR, registered read port and pulse-separated nIRQ FSM.
module uart_int_ctrl_gen2
  import uart_int_ctrl_gen2_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int GAP_CYC = 2,
  parameter int DATA_W  = 16
) (
  input  logic              DSP_CLK,
  input  logic              RESET,
  input  logic              DSP_CEn,
  input  logic              DSP_WEn,
  input  logic [3:0]        DSP_ADDR,
  input  logic [DATA_W-1:0] DSP_WDATA,
  output logic [DATA_W-1:0] DSP_RDATA,
  input  logic [N_SRC-1:0]  INT_SRC,
  output logic              nIRQ
);

  logic              busWr;
  logic              busRd;
  logic              ackWr;
  logic [N_SRC-1:0]  wrBits;
  logic [N_SRC-1:0]  ier;
  logic [N_SRC-1:0]  mode;
  logic [N_SRC-1:0]  isr;
  logic [N_SRC-1:0]  setW1s;
  logic [N_SRC-1:0]  clrW1c;
  logic [N_SRC-1:0]  active;
  logic              pending;
  logic [DATA_W-1:0] iirWord;
  logic [DATA_W-1:0] readWord;
  irqState_t         state;
  irqState_t         stateNext;
  logic [3:0]        gapCnt;
  logic [3:0]        gapNext;
  logic              unusedWdata;

  assign busWr  = ~DSP_CEn & ~DSP_WEn;
  assign busRd  = ~DSP_CEn &  DSP_WEn;
  assign wrBits = DSP_WDATA[N_SRC-1:0];
  assign ackWr  = busWr && (DSP_ADDR == ADDR_ISR);
  assign setW1s = (busWr && (DSP_ADDR == ADDR_SET)) ? wrBits : '0;
  assign clrW1c = ackWr ? wrBits : '0;
  assign unusedWdata = ^DSP_WDATA;

  always_ff @(posedge DSP_CLK) begin
    if (RESET) begin
      ier  <= '0;
      mode <= '0;
    end else if (busWr) begin
      if (DSP_ADDR == ADDR_IER)  ier  <= wrBits;
      if (DSP_ADDR == ADDR_MODE) mode <= wrBits;
    end
  end

  for (genvar i = 0; i < N_SRC; i++) begin : genSrc
    uart_int_src_cell srcCell (
      .DSP_CLK  (DSP_CLK),
      .RESET    (RESET),
      .src      (INT_SRC[i]),
      .enable   (ier[i]),
      .edgeMode (mode[i]),
      .setBit   (setW1s[i]),
      .clrBit   (clrW1c[i]),
      .status   (isr[i])
    );
  end

  assign active  = isr & ier;
  assign pending = |active;

  always_comb begin
    iirWord = '0;
    iirWord[IIR_PEND_BIT]       = pending;
    iirWord[IIR_ID_W-1:0]       = firstSetIdx(MAX_SRC'(active));
  end

  // NOTE: combinational blocks assign a default before any branch so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    readWord = '0;
    case (DSP_ADDR)
      ADDR_IER:  readWord[N_SRC-1:0] = ier;
      ADDR_ISR:  readWord[N_SRC-1:0] = isr;
      ADDR_IIR:  readWord            = iirWord;
      ADDR_MODE: readWord[N_SRC-1:0] = mode;
      ADDR_RAW:  readWord[N_SRC-1:0] = INT_SRC;
      default:   readWord            = '0;
    endcase
  end

  // Read data holds its last value until the next read; writes leave it alone.
  always_ff @(posedge DSP_CLK) begin
    if (RESET)      DSP_RDATA <= '0;
    else if (busRd) DSP_RDATA <= readWord;
  end

  always_comb begin
    stateNext = state;
    gapNext   = gapCnt;
    case (state)
      IRQ_IDLE: begin
        if (pending) stateNext = IRQ_ASSERT;
      end
      IRQ_ASSERT: begin
        if (ackWr) begin
          if (GAP_CYC == 0) begin
            stateNext = IRQ_IDLE;
          end else begin
            stateNext = IRQ_GAP;
            gapNext   = 4'(GAP_CYC);
          end
        end else if (!pending) begin
          stateNext = IRQ_IDLE;
        end
      end
      IRQ_GAP: begin
        gapNext = gapCnt - 4'd1;
        if (gapCnt <= 4'd1) stateNext = IRQ_IDLE;
      end
      default: stateNext = IRQ_IDLE;
    endcase
  end

  // nIRQ comes from its own flop loaded from the next state, so it never glitches.
  always_ff @(posedge DSP_CLK) begin
    if (RESET) begin
      state  <= IRQ_IDLE;
      gapCnt <= '0;
      nIRQ   <= 1'b1;
    end else begin
      state  <= stateNext;
      gapCnt <= gapNext;
      nIRQ   <= (stateNext != IRQ_ASSERT);
    end
  end

endmodule
